// File: rtl/l1_dcache_pkg.sv
// cache_types: shared constants and the controller state encoding for the
// L1 data cache. The line is fixed at 256 bits (8 x 32-bit words). Widths
// named *_DEF are the default set-index/offset split; the top derives its
// own tag width from its parameters.
package cache_types;
  localparam int ADDR_W       = 32;
  localparam int WORD_W       = 32;
  localparam int LINE_W       = 256;
  localparam int LINE_BYTES   = LINE_W / 8;
  localparam int LINE_WORDS   = LINE_W / WORD_W;
  localparam int S_OFFSET_DEF = 5;
  localparam int S_INDEX_DEF  = 3;
  localparam int TAG_W_DEF    = ADDR_W - S_INDEX_DEF - S_OFFSET_DEF;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } cache_state_e;
endpackage

// File: rtl/l1_dcache_if.sv
// l1_dcache_if: CPU-side request bus plus the line-wide memory bus of the
// L1 data cache.
//   master : the environment (CPU drives mem_*, memory drives pmem_rdata/resp)
//   slave  : the cache
interface l1_dcache_if;
  import cache_types::*;

  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_W-1:0]     mem_address;
  logic [WORD_W-1:0]     mem_wdata;
  logic [3:0]            mem_byte_enable;
  logic [WORD_W-1:0]     mem_rdata;
  logic                  mem_resp;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_W-1:0]     pmem_address;
  logic [LINE_W-1:0]     pmem_wdata;
  logic [LINE_W-1:0]     pmem_rdata;
  logic                  pmem_resp;

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    output pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
    input  pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/l1_dcache_array.sv
// l1_dcache_array: direct-mapped line storage, 2**S_INDEX sets.
//   index      : set being read and written
//   byte_we    : per-byte write enable across the 256-bit line
//   wdata      : line write data (bytes taken where byte_we=1)
//   meta_we    : load tag_in, set valid, load dirty_in for the set
//   rdata/tag_out/valid_out/dirty_out : asynchronous read of the set
// Only valid/dirty are reset; tag and data come up undefined and are
// never looked at until valid is set.
module l1_dcache_array
  import cache_types::*;
#(
  parameter int S_INDEX = S_INDEX_DEF,
  parameter int TAG_W   = TAG_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [S_INDEX-1:0]    index,
  input  logic [LINE_BYTES-1:0] byte_we,
  input  logic [LINE_W-1:0]     wdata,
  input  logic                  meta_we,
  input  logic [TAG_W-1:0]      tag_in,
  input  logic                  dirty_in,
  output logic [LINE_W-1:0]     rdata,
  output logic [TAG_W-1:0]      tag_out,
  output logic                  valid_out,
  output logic                  dirty_out
);
  localparam int SETS = 1 << S_INDEX;

  logic [SETS-1:0]  valid_q;
  logic [SETS-1:0]  dirty_q;
  logic [TAG_W-1:0] tag_q [SETS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (meta_we) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= dirty_in;
    end
  end

  always_ff @(posedge clk) begin
    if (meta_we) tag_q[index] <= tag_in;
  end

  // One storage column per byte lane so each lane has a single writer.
  for (genvar b = 0; b < LINE_BYTES; b++) begin : g_byte
    logic [7:0] mem_q [SETS];
    always_ff @(posedge clk) begin
      if (byte_we[b]) mem_q[index] <= wdata[b*8 +: 8];
    end
    assign rdata[b*8 +: 8] = mem_q[index];
  end

  assign tag_out   = tag_q[index];
  assign valid_out = valid_q[index];
  assign dirty_out = dirty_q[index];
endmodule

// File: rtl/l1_dcache.sv
// l1_dcache: direct-mapped, write-back, write-allocate L1 data cache.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : l1_dcache_if.slave (CPU word requests, memory line transfers)
// Hits complete combinationally in IDLE. A miss optionally writes the dirty
// victim back (WRITEBACK), fills the line (ALLOCATE), then returns to IDLE
// where the still-held request completes as a hit.
module l1_dcache
  import cache_types::*;
#(
  parameter int S_INDEX  = S_INDEX_DEF,
  parameter int S_OFFSET = S_OFFSET_DEF
) (
  input  logic         clk,
  input  logic         rst,
  l1_dcache_if.slave   bus
);
  localparam int TAG_W  = ADDR_W - S_INDEX - S_OFFSET;
  localparam int WSEL_W = S_OFFSET - 2;

  cache_state_e state_q, state_d;

  logic [S_INDEX-1:0]    index;
  logic [TAG_W-1:0]      req_tag, line_tag, tag_in;
  logic [WSEL_W-1:0]     wsel;
  logic [LINE_W-1:0]     line_rdata, line_wdata;
  logic [LINE_BYTES-1:0] byte_we, wr_be;
  logic                  line_valid, line_dirty, meta_we, dirty_in;
  logic                  req, hit;
  logic                  mem_resp, pmem_read, pmem_write;
  logic [ADDR_W-1:0]     pmem_address;
  logic                  addr_unused;

  assign index       = bus.mem_address[S_OFFSET +: S_INDEX];
  assign req_tag     = bus.mem_address[ADDR_W-1 -: TAG_W];
  assign wsel        = bus.mem_address[S_OFFSET-1:2];
  assign addr_unused = ^bus.mem_address[1:0];

  assign req = bus.mem_read | bus.mem_write;
  assign hit = line_valid && (line_tag == req_tag);

  // 4-bit word mask placed at the addressed word of the 32-byte line.
  assign wr_be = LINE_BYTES'(bus.mem_byte_enable) << {wsel, 2'b00};

  l1_dcache_array #(
    .S_INDEX (S_INDEX),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .index     (index),
    .byte_we   (byte_we),
    .wdata     (line_wdata),
    .meta_we   (meta_we),
    .tag_in    (tag_in),
    .dirty_in  (dirty_in),
    .rdata     (line_rdata),
    .tag_out   (line_tag),
    .valid_out (line_valid),
    .dirty_out (line_dirty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {req_tag, index, S_OFFSET'(0)};
    byte_we      = '0;
    line_wdata   = {LINE_WORDS{bus.mem_wdata}};
    meta_we      = 1'b0;
    tag_in       = req_tag;
    dirty_in     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp = 1'b1;
            // A write wins when both strobes are high. An empty mask
            // completes without touching data or dirty.
            if (bus.mem_write) begin
              byte_we = wr_be;
              if (|bus.mem_byte_enable) begin
                meta_we  = 1'b1;
                dirty_in = 1'b1;
              end
            end
          end else if (line_valid && line_dirty) begin
            state_d = WRITEBACK;
          end else begin
            state_d = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {line_tag, index, S_OFFSET'(0)};
        if (bus.pmem_resp) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        if (bus.pmem_resp) begin
          byte_we    = '1;
          line_wdata = bus.pmem_rdata;
          meta_we    = 1'b1;
          dirty_in   = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gating on hit keeps never-written (undefined) lines off the read port.
  assign bus.mem_rdata    = hit ? line_rdata[wsel*WORD_W +: WORD_W] : '0;
  assign bus.mem_resp     = mem_resp;
  assign bus.pmem_read    = pmem_read;
  assign bus.pmem_write   = pmem_write;
  assign bus.pmem_address = pmem_address;
  assign bus.pmem_wdata   = line_rdata;
endmodule

// File: tb/tb_l1_dcache.sv
// tb_l1_dcache: directed vectors for l1_dcache with a line-memory responder
// of programmable latency that also checks strobe/address stability.
module tb_l1_dcache;
  import cache_types::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  l1_dcache_if bus();

  l1_dcache #(.S_INDEX(3), .S_OFFSET(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_vec = 0;
  int n_bad = 0;
  int lat = 1;
  int n_rd = 0, n_wr = 0, stable_err = 0, both_err = 0;
  logic [31:0]  last_rd_addr, last_wr_addr;
  logic [255:0] last_wr_data;
  time          last_rd_t, last_wr_t;
  logic [255:0] pmem [logic [31:0]];

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mbe;
    bit          chk_data;
    logic [31:0] exp_data;
    int          exp_cyc;
    int          exp_prd;
    int          exp_pwr;
    logic [31:0] wb_addr;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory responder: after `lat` cycles of a held strobe, pulse pmem_resp.
  initial begin : responder
    bit rd, wr, ok;
    logic [31:0] a;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      while (rst && (bus.pmem_read || bus.pmem_write)) begin
        rd = bus.pmem_read;
        wr = bus.pmem_write;
        a  = bus.pmem_address;
        ok = 1'b1;
        if (rd) begin n_rd++; last_rd_addr = a; last_rd_t = $time; end
        if (wr) begin n_wr++; last_wr_addr = a; last_wr_data = bus.pmem_wdata; last_wr_t = $time; end
        for (int i = 1; i < lat; i++) begin
          @(negedge clk);
          if (!rst) begin ok = 1'b0; break; end
          if (bus.pmem_read !== rd || bus.pmem_write !== wr ||
              bus.pmem_address !== a || bus.mem_resp !== 1'b0) stable_err++;
        end
        if (ok) begin
          if (wr) pmem[a] = bus.pmem_wdata;
          bus.pmem_rdata = (rd && pmem.exists(a)) ? pmem[a] : '0;
          bus.pmem_resp  = 1'b1;
          @(negedge clk);
          bus.pmem_resp  = 1'b0;
          bus.pmem_rdata = '0;
        end
      end
    end
  end

  always @(negedge clk) if (bus.pmem_read && bus.pmem_write) both_err++;

  // Issue one CPU request at posedge+1 and hold it until mem_resp.
  // cyc counts sampled cycles up to and including the response (-1 on timeout).
  task automatic cpu_op(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be,
                        output logic [31:0] rdat, output int cyc);
    bit got = 1'b0;
    bus.mem_read = rd; bus.mem_write = wr; bus.mem_address = a;
    bus.mem_wdata = wd; bus.mem_byte_enable = be;
    rdat = 'x;
    cyc = 0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_resp) begin got = 1'b1; rdat = bus.mem_rdata; end
    end
    if (!got) cyc = -1;
    @(posedge clk); #1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    logic [31:0] rdat;
    int cyc, rd0, wr0;
    rd0 = n_rd; wr0 = n_wr;
    cpu_op(v.rd, v.wr, v.addr, v.wdata, v.mbe, rdat, cyc);
    chk({nm, " latency"}, 256'(cyc), 256'(v.exp_cyc));
    if (v.chk_data) chk({nm, " rdata"}, 256'(rdat), 256'(v.exp_data));
    chk({nm, " pmem_read count"},  256'(n_rd - rd0), 256'(v.exp_prd));
    chk({nm, " pmem_write count"}, 256'(n_wr - wr0), 256'(v.exp_pwr));
    if (v.exp_prd != 0) chk({nm, " fill addr"}, 256'(last_rd_addr), 256'({v.addr[31:5], 5'b0}));
    if (v.exp_pwr != 0) chk({nm, " wb addr"}, 256'(last_wr_addr), 256'(v.wb_addr));
  endtask

  initial begin : main
    logic [255:0] line, exp_line;
    vec_t v;

    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_address = '0;
    bus.mem_wdata = '0; bus.mem_byte_enable = '0;

    line = '0; line[63:32]   = 32'hDEADBEEF; pmem[32'h40]  = line;
    line = '0; line[31:0]    = 32'hCAFEF00D; pmem[32'h140] = line;
    line = '0; line[255:224] = 32'h5A5A0007; pmem[32'h200] = line;

    // rd wr addr wdata mbe chk exp cyc prd pwr wb_addr   (lat = 1)
    vecs[0] = '{1, 0, 32'h40,  32'h0,        4'h0, 1, 32'h0,        3, 1, 0, 32'h0};
    vecs[1] = '{1, 0, 32'h44,  32'h0,        4'h0, 1, 32'hDEADBEEF, 1, 0, 0, 32'h0};
    vecs[2] = '{0, 1, 32'h44,  32'h11223344, 4'h3, 0, 32'h0,        1, 0, 0, 32'h0};
    vecs[3] = '{1, 0, 32'h44,  32'h0,        4'h0, 1, 32'hDEAD3344, 1, 0, 0, 32'h0};
    vecs[4] = '{0, 1, 32'h48,  32'hFFFFFFFF, 4'h0, 0, 32'h0,        1, 0, 0, 32'h0};
    vecs[5] = '{1, 0, 32'h48,  32'h0,        4'h0, 1, 32'h0,        1, 0, 0, 32'h0};
    vecs[6] = '{1, 1, 32'h4C,  32'hA5A5A5A5, 4'hF, 0, 32'h0,        1, 0, 0, 32'h0};
    vecs[7] = '{1, 0, 32'h4C,  32'h0,        4'h0, 1, 32'hA5A5A5A5, 1, 0, 0, 32'h0};
    vecs[8] = '{1, 0, 32'h140, 32'h0,        4'h0, 1, 32'hCAFEF00D, 4, 1, 1, 32'h40};
    vecs[9] = '{1, 0, 32'h44,  32'h0,        4'h0, 1, 32'hDEAD3344, 3, 1, 0, 32'h0};

    #12;
    chk("reset pmem_read",  256'(bus.pmem_read),  256'(0));
    chk("reset pmem_write", 256'(bus.pmem_write), 256'(0));
    chk("reset mem_resp",   256'(bus.mem_resp),   256'(0));
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Writeback of the modified tag-0 line must precede the fill.
    exp_line = '0;
    exp_line[63:32]  = 32'hDEAD3344;
    exp_line[127:96] = 32'hA5A5A5A5;
    chk("wb data", last_wr_data, exp_line);
    chk("wb before fill", 256'(last_wr_t < last_rd_t), 256'(1));

    run_vec(vecs[9], "v9");

    // Slow memory: strobes and address held, no mem_resp while waiting.
    lat = 10;
    v = '{1, 0, 32'h21C, 32'h0, 4'h0, 1, 32'h5A5A0007, 12, 1, 0, 32'h0};
    run_vec(v, "slow fill");
    chk("slow fill stability", 256'(stable_err), 256'(0));

    // Reset in the middle of a fill.
    bus.mem_read = 1'b1; bus.mem_address = 32'h300; bus.mem_byte_enable = 4'h0;
    repeat (3) @(negedge clk);
    chk("mid-fill pmem_read", 256'(bus.pmem_read), 256'(1));
    #2 rst = 1'b0;
    #1;
    chk("async drop pmem_read", 256'(bus.pmem_read), 256'(0));
    chk("async drop mem_resp",  256'(bus.mem_resp),  256'(0));
    bus.mem_read = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    lat = 1;
    v = '{1, 0, 32'h300, 32'h0, 4'h0, 1, 32'h0, 3, 1, 0, 32'h0};
    run_vec(v, "refill after reset");
    v = '{1, 0, 32'h44, 32'h0, 4'h0, 1, 32'hDEAD3344, 3, 1, 0, 32'h0};
    run_vec(v, "valid cleared");

    chk("read/write exclusive", 256'(both_err), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/l1_dcache.md
L1_DCACHE -- requirements
Module: l1_dcache

Interface
REQ-001 Parameter S_INDEX, default 3, set-index width; the cache SHALL have 2**S_INDEX sets.
REQ-002 Parameter S_OFFSET, default 5, byte-offset width; the line SHALL be 256 bits (32 bytes).
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 mem_read  input  1  CPU read request, held until mem_resp.
REQ-006 mem_write  input  1  CPU write request, held until mem_resp.
REQ-007 mem_address  input  32  CPU byte address, word-aligned ([1:0]=0).
REQ-008 mem_wdata  input  32  CPU write data, already lane-shifted.
REQ-009 mem_byte_enable  input  4  CPU byte-lane write mask.
REQ-010 mem_rdata  output  32  addressed word of the selected line.
REQ-011 mem_resp  output  1  one-cycle completion pulse per request.
REQ-012 pmem_read  output  1  line fill request, held until pmem_resp.
REQ-013 pmem_write  output  1  line writeback request, held until pmem_resp.
REQ-014 pmem_address  output  32  line-aligned address ([4:0]=0).
REQ-015 pmem_wdata  output  256  victim line data.
REQ-016 pmem_rdata  input  256  fill line data, valid when pmem_resp=1.
REQ-017 pmem_resp  input  1  memory completion pulse.

Function
REQ-018 Address split: offset [4:0], word select [4:2], index [S_OFFSET+S_INDEX-1:S_OFFSET], tag = remaining upper bits (24 at default).
REQ-019 Organisation: direct-mapped, write-back, write-allocate; per set: valid, dirty, tag, 256-bit data.
REQ-020 FSM states: IDLE, WRITEBACK, ALLOCATE.
REQ-021 IDLE, request, hit (valid and tag match): mem_resp=1 in the same cycle (combinational); mem_rdata = line word [word select].
REQ-022 Write hit: bytes with mem_byte_enable=1 updated at the next edge and dirty set; bytes with enable=0 unchanged; mem_byte_enable=0000 SHALL respond without modifying data or dirty.
REQ-023 IDLE, miss, victim clean or invalid -> ALLOCATE; victim valid and dirty -> WRITEBACK; mem_resp=0 on a miss.
REQ-024 WRITEBACK: pmem_write=1, pmem_address = {victim tag, index, 5'b0}, pmem_wdata = victim line; on pmem_resp -> ALLOCATE.
REQ-025 ALLOCATE: pmem_read=1, pmem_address = {request tag, index, 5'b0}; on pmem_resp, pmem_rdata written to line, tag loaded, valid=1, dirty=0, -> IDLE.
REQ-026 After ALLOCATE, IDLE SHALL service the held request as a hit: clean-miss latency = pmem latency + 1 cycle; dirty-miss latency additionally includes the writeback.
REQ-027 pmem_read and pmem_write SHALL never both be 1; each SHALL remain stable until pmem_resp.
REQ-028 mem_read and mem_write both 1: treated as a write.
REQ-029 mem_resp SHALL be 0 outside IDLE; no request in IDLE -> all strobes 0.
REQ-030 mem_rdata on a write response or with no request: don't-care, but SHALL be free of X propagation from reset-initialised sets.

Reset
REQ-031 rst=0 SHALL immediately force: state IDLE; all valid and dirty bits 0; mem_resp, pmem_read and pmem_write 0.
REQ-032 Tag and data arrays SHALL not be reset.
REQ-033 Reset during WRITEBACK or ALLOCATE SHALL abandon the transfer without updating any array; the pmem strobe drops asynchronously.

Structure
REQ-034 Package cache_types SHALL hold the FSM state enum, the line width (256), and the tag/index/offset width constants.
REQ-035 One sub-module, l1_dcache_array: storage for 2**S_INDEX lines, 32-bit per-byte write enable, asynchronous read.
REQ-036 Hit detection, byte-enable expansion and the FSM SHALL live in l1_dcache.

Verification
REQ-037 After reset, read 0x0000_0040 -> pmem_read at 0x0000_0040; pmem_rdata word1=0xDEADBEEF, other words 0; then read 0x0000_0044 -> mem_rdata=0xDEADBEEF, mem_resp one cycle after pmem_resp.
REQ-038 Write hit at 0x44, wdata=0x11223344, mbe=0011 -> next read of 0x44 returns 0xDEAD3344; no pmem traffic.
REQ-039 Dirty line (tag 0) at index 2; read 0x0000_0140 -> pmem_write at 0x40 with the modified line, then pmem_read at 0x140, then mem_resp.
REQ-040 Request held while pmem_resp is delayed 10 cycles -> strobes and pmem_address stable, mem_resp=0 throughout.
REQ-041 rst asserted mid-ALLOCATE -> pmem_read drops the same cycle; after release, re-read of the same address misses again.
REQ-042 mem_read and mem_write both 1 on a hit, mbe=1111 -> data written, dirty set, single mem_resp.
